nn_layer_seq: RTL and testbench

Sequencer that runs one fully-connected layer of NEURONS neurons, each with 4 inputs, on a single shared mac4 dot-product engine. For each neuron it fetches a packed weight vector and bias from an external synchronous memory and drives the mac4 start/done handshake. It then applies bias, shift and saturation and streams one BW-bit result per neuron. It sits between the top-level inference controller and the mac4 instance.

---
 rtl/nn_layer_seq.sv | 143 ++++++++++++++
 tb/tb_nn_layer_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_seq.sv
// Fully-connected layer sequencer: walks NEURONS neurons through one shared mac4,
// fetching weights/bias from a synchronous memory and streaming saturated results.
module nn_layer_seq #(
  parameter int unsigned BW      = 8,
  parameter int unsigned NEURONS = 4,
  parameter int unsigned AW      = 2,
  parameter int unsigned SHIFT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*BW-1:0]   x_in,
  output logic              busy,
  output logic              done,
  output logic              w_rd_en,
  output logic [AW-1:0]     w_addr,
  input  logic [4*BW-1:0]   w_data,
  input  logic [BW-1:0]     b_data,
  output logic              mac_start,
  output logic [4*BW-1:0]   mac_x,
  output logic [4*BW-1:0]   mac_w,
  input  logic [2*BW+1:0]   mac_sum,
  input  logic              mac_done,
  output logic              out_valid,
  output logic [AW-1:0]     out_idx,
  output logic [BW-1:0]     out_data
);

  localparam int unsigned SW = 2*BW + 2;
  localparam int unsigned TW = 2*BW + 3;
  localparam logic [AW-1:0] LAST = AW'(NEURONS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    RUN    = 3'd3,
    POST   = 3'd4,
    DRAIN  = 3'd5,
    FINISH = 3'd6
  } state_t;

  state_t        state;
  logic [AW-1:0] n;
  logic [BW-1:0] b_reg;
  logic [SW-1:0] sum_reg;

  logic [TW-1:0] t_c;
  logic [TW-1:0] s_c;
  logic [BW-1:0] sat_c;

  // Bias add, scale down, clamp to the BW-bit unsigned range.
  always_comb begin
    t_c   = TW'(sum_reg) + TW'(b_reg);
    s_c   = t_c >> SHIFT;
    sat_c = (s_c > TW'({BW{1'b1}})) ? {BW{1'b1}} : s_c[BW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_rd_en   <= 1'b0;
      w_addr    <= '0;
      mac_start <= 1'b0;
      mac_x     <= '0;
      mac_w     <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      n         <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mac_x   <= x_in;
            n       <= '0;
            busy    <= 1'b1;
            w_rd_en <= 1'b1;
            w_addr  <= '0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          w_rd_en <= 1'b0;
          state   <= LOAD;
        end
        LOAD: begin
          mac_w     <= w_data;
          b_reg     <= b_data;
          mac_start <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (mac_done) begin
            sum_reg   <= mac_sum;
            mac_start <= 1'b0;
            state     <= POST;
          end
        end
        POST: begin
          out_data  <= sat_c;
          out_idx   <= n;
          out_valid <= 1'b1;
          state     <= DRAIN;
        end
        DRAIN: begin
          // mac4 holds done until it is back in idle; never restart it before then.
          out_valid <= 1'b0;
          if (!mac_done) begin
            if (n == LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FINISH;
            end else begin
              n       <= n + AW'(1);
              w_addr  <= n + AW'(1);
              w_rd_en <= 1'b1;
              state   <= FETCH;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          w_rd_en   <= 1'b0;
          mac_start <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// Bench for nn_layer_seq: behavioural mac4 + weight memory, expected-result queue
// built from plain dot-product arithmetic, and a per-cycle output checker.
module tb_nn_layer_seq;

  localparam int unsigned BW      = 8;
  localparam int unsigned NEURONS = 4;
  localparam int unsigned AW      = 2;
  localparam int unsigned SHIFT   = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [4*BW-1:0]   x_in;
  logic              busy;
  logic              done;
  logic              w_rd_en;
  logic [AW-1:0]     w_addr;
  logic [4*BW-1:0]   w_data;
  logic [BW-1:0]     b_data;
  logic              mac_start;
  logic [4*BW-1:0]   mac_x;
  logic [4*BW-1:0]   mac_w;
  logic [2*BW+1:0]   mac_sum;
  logic              mac_done;
  logic              out_valid;
  logic [AW-1:0]     out_idx;
  logic [BW-1:0]     out_data;

  nn_layer_seq #(.BW(BW), .NEURONS(NEURONS), .AW(AW), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data), .b_data(b_data),
    .mac_start(mac_start), .mac_x(mac_x), .mac_w(mac_w), .mac_sum(mac_sum),
    .mac_done(mac_done), .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [4*BW-1:0] mem_w [NEURONS];
  logic [BW-1:0]   mem_b [NEURONS];

  // Synchronous weight/bias memory, one cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      w_data <= '0;
      b_data <= '0;
    end else if (w_rd_en) begin
      w_data <= mem_w[w_addr];
      b_data <= mem_b[w_addr];
    end
  end

  function automatic int unsigned dot4(input logic [4*BW-1:0] x, input logic [4*BW-1:0] w);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 4; i++) s += 32'(x[i*BW +: BW]) * 32'(w[i*BW +: BW]);
    return s;
  endfunction

  function automatic int unsigned model_out(input logic [4*BW-1:0] x, input logic [4*BW-1:0] w,
                                            input logic [BW-1:0] b);
    int unsigned s;
    s = (dot4(x, w) + 32'(b)) >> SHIFT;
    return (s > 255) ? 255 : s;
  endfunction

  // mac4 behaviour: random latency, done held until start drops, cleared one cycle after idle.
  int m_state;
  int m_cnt;
  always @(posedge clk) begin
    if (rst) begin
      m_state  <= 0;
      m_cnt    <= 0;
      mac_done <= 1'b0;
      mac_sum  <= '0;
    end else begin
      case (m_state)
        0: begin
          if (mac_done) mac_done <= 1'b0;
          else if (mac_start) begin
            mac_sum <= 18'(dot4(mac_x, mac_w));
            m_cnt   <= int'($urandom_range(3, 1));
            m_state <= 1;
          end
        end
        1: begin
          if (m_cnt <= 1) begin
            mac_done <= 1'b1;
            m_state  <= 2;
          end else m_cnt <= m_cnt - 1;
        end
        default: if (!mac_start) m_state <= 0;
      endcase
    end
  end

  int exp_idx_q[$];
  int exp_dat_q[$];
  bit done_exp = 1'b0;
  int n_done = 0;
  int n_valid = 0;
  logic            p_start = 1'b0;
  logic [4*BW-1:0] p_x = '0;
  logic [4*BW-1:0] p_w = '0;

  // Per-cycle output checker, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        n_valid++;
        checks++;
        if (exp_idx_q.size() == 0) begin
          errors++;
          $display("FAIL extra_result got idx %0d data %0d want none", out_idx, out_data);
        end else begin
          int ei, ed;
          ei = exp_idx_q.pop_front();
          ed = exp_dat_q.pop_front();
          if (int'(out_idx) != ei || int'(out_data) != ed) begin
            errors++;
            $display("FAIL result got idx %0d data %0d want idx %0d data %0d",
                     out_idx, out_data, ei, ed);
          end
        end
      end
      if (done) begin
        n_done++;
        checks++;
        if (!done_exp || busy || exp_idx_q.size() != 0) begin
          errors++;
          $display("FAIL done_pulse got busy %0b pending %0d expected %0b want busy 0 pending 0 expected 1",
                   busy, exp_idx_q.size(), done_exp);
        end
        done_exp = 1'b0;
      end
      if (mac_start && !p_start) begin
        checks++;
        if (mac_done) begin
          errors++;
          $display("FAIL mac_start_rise got mac_done 1 want 0");
        end
      end
      if (mac_start && p_start) begin
        checks++;
        if (mac_x != p_x || mac_w != p_w) begin
          errors++;
          $display("FAIL operand_stable got x %h w %h want x %h w %h", mac_x, mac_w, p_x, p_w);
        end
      end
      p_start = mac_start;
      p_x     = mac_x;
      p_w     = mac_w;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rd_en"}, 32'(w_rd_en), 0);
    chk({tag, "_w_addr"}, 32'(w_addr), 0);
    chk({tag, "_mac_start"}, 32'(mac_start), 0);
    chk({tag, "_mac_x"}, mac_x, 0);
    chk({tag, "_mac_w"}, mac_w, 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_idx"}, 32'(out_idx), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
  endtask

  task automatic load(input int k, input logic [4*BW-1:0] w, input logic [BW-1:0] b);
    mem_w[k] = w;
    mem_b[k] = b;
  endtask

  task automatic launch(input logic [4*BW-1:0] x);
    n_valid = 0;
    for (int k = 0; k < int'(NEURONS); k++) begin
      exp_idx_q.push_back(k);
      exp_dat_q.push_back(int'(model_out(x, mem_w[k], mem_b[k])));
    end
    done_exp = 1'b1;
    x_in  = x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic run_layer(input string name, input logic [4*BW-1:0] x, input bit noise);
    bit seen;
    launch(x);
    if (noise) begin
      for (int j = 0; j < 3; j++) begin
        x_in  = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout got no done want done", name);
    end
    @(negedge clk);
    chk({name, "_busy_idle"}, 32'(busy), 0);
    chk({name, "_n_valid"}, 32'(n_valid), NEURONS);
  endtask

  initial begin
    int base;
    bit hit;
    rst   = 1'b1;
    start = 1'b0;
    x_in  = '0;
    for (int k = 0; k < int'(NEURONS); k++) load(k, '0, '0);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // x = {64,48,32,16}, w = 1: 160 >> 4 = 10.
    for (int k = 0; k < int'(NEURONS); k++) load(k, 32'h0101_0101, 8'd0);
    chk("pin_basic", model_out(32'h4030_2010, 32'h0101_0101, 8'd0), 10);
    run_layer("basic", 32'h4030_2010, 1'b0);

    // Bias and shift mix.
    load(0, 32'h0202_0202, 8'd40);
    load(1, 32'h0202_0202, 8'd0);
    load(2, 32'h0000_0000, 8'd255);
    load(3, 32'h0101_0101, 8'd8);
    chk("pin_bias_shift", model_out(32'h0A0A_0A0A, 32'h0202_0202, 8'd40), 7);
    chk("pin_bias_only", model_out(32'h0A0A_0A0A, 32'h0000_0000, 8'd255), 15);
    run_layer("bias_shift", 32'h0A0A_0A0A, 1'b0);

    // Saturation and uneven weights.
    load(0, 32'hFFFF_FFFF, 8'd255);
    load(1, 32'h0101_0101, 8'd0);
    load(2, 32'h0000_0000, 8'd255);
    load(3, 32'h0102_0304, 8'd16);
    chk("pin_saturate", model_out(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd255), 255);
    chk("pin_uneven", model_out(32'hFFFF_FFFF, 32'h0102_0304, 8'd16), 160);
    run_layer("saturate", 32'hFFFF_FFFF, 1'b0);

    // Full layer, weights k+1, with ignored start pulses while busy.
    for (int k = 0; k < int'(NEURONS); k++) load(k, {4{8'(k + 1)}}, 8'd0);
    chk("pin_full_n3", model_out(32'h1010_1010, 32'h0404_0404, 8'd0), 16);
    run_layer("full_noise", 32'h1010_1010, 1'b1);

    // Reset during RUN of neuron 2, then a clean rerun.
    launch(32'h1010_1010);
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (mac_start && w_addr == 2'd2) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_run_reach got no run of neuron 2 want run of neuron 2");
    end
    rst = 1'b1;
    exp_idx_q.delete();
    exp_dat_q.delete();
    done_exp = 1'b0;
    base = n_done;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_done_after_abort", 32'(n_done - base), 0);
    run_layer("after_reset", 32'h1010_1010, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
